// File: rtl/rsa_two_power_mod_multi_pkg.sv
// Shared types and constants for the 2^e mod N constant generator.
// Optional o_err output is enabled by defining RSA_TWO_POWER_MOD_ERR_EN.
package rsa_two_power_mod_multi_pkg;

   localparam int MOD_WIDTH = 256;
   localparam int TWO_POW_STEP_DEFAULT = 1;

   typedef logic [MOD_WIDTH-1:0] KeyType;
   typedef logic [MOD_WIDTH:0]   ExtendKeyType;
   typedef logic [31:0]          IntType;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } TwoPowState_t;

endpackage

// File: rtl/rsa_two_power_mod_multi_step.sv
// One modular doubling: r' = 2r mod N, given r < N.
// Purely combinational; chained STEP times by the top.
module rsa_two_power_mod_multi_step
   import rsa_two_power_mod_multi_pkg::*;
#(
   parameter int WIDTH = MOD_WIDTH
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH:0]   r_nxt
);

   logic [WIDTH:0] t;
   logic [WIDTH:0] n_ext;

   // r < N < 2^WIDTH, so 2r fits in WIDTH+1 bits and one subtract suffices
   always_comb begin
      t     = r << 1;
      n_ext = {1'b0, n};
      r_nxt = (t >= n_ext) ? (t - n_ext) : t;
   end

endmodule

// File: rtl/rsa_two_power_mod_multi.sv
// Computes o_out = 2^i_power mod i_modulus, STEP doublings per cycle.
// Define RSA_TWO_POWER_MOD_ERR_EN to expose o_err for a zero modulus.
module rsa_two_power_mod_multi
   import rsa_two_power_mod_multi_pkg::*;
#(
   parameter int WIDTH     = MOD_WIDTH,
   parameter int POW_WIDTH = $bits(IntType),
   parameter int STEP      = TWO_POW_STEP_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_abort,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [WIDTH-1:0]     i_modulus,
   input  logic [POW_WIDTH-1:0] i_power,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [WIDTH-1:0]     o_out
`ifdef RSA_TWO_POWER_MOD_ERR_EN
  ,output logic                 o_err
`endif
);

   TwoPowState_t         state;
   logic [WIDTH-1:0]     n_q;
   logic [POW_WIDTH-1:0] rem_q;
   logic [WIDTH:0]       acc_q;

   logic [WIDTH:0]       chain [STEP+1];
   logic [WIDTH:0]       acc_nxt;
   logic [POW_WIDTH-1:0] k_w;
   logic [POW_WIDTH-1:0] rem_nxt;
   logic                 n_is_one;

   assign chain[0] = acc_q;

   // Doubling chain; stages past rem pass the value through
   for (genvar j = 0; j < STEP; j++) begin : g_step
      logic [WIDTH:0] dbl;
      rsa_two_power_mod_multi_step #(
         .WIDTH(WIDTH)
      ) u_step (
         .r    (chain[j]),
         .n    (n_q),
         .r_nxt(dbl)
      );
      assign chain[j+1] = (POW_WIDTH'(j) < rem_q) ? dbl : chain[j];
   end

   // Steps taken this cycle: min(STEP, rem)
   always_comb begin
      acc_nxt  = chain[STEP];
      k_w      = (rem_q > POW_WIDTH'(STEP)) ? POW_WIDTH'(STEP) : rem_q;
      rem_nxt  = rem_q - k_w;
      n_is_one = (i_modulus == WIDTH'(1));
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         i_ready <= 1'b1;
         o_valid <= 1'b0;
         o_out   <= '0;
         n_q     <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
`ifdef RSA_TWO_POWER_MOD_ERR_EN
         o_err   <= 1'b0;
`endif
      end else if (i_abort) begin
         state   <= IDLE;
         i_ready <= 1'b1;
         o_valid <= 1'b0;
         rem_q   <= '0;
`ifdef RSA_TWO_POWER_MOD_ERR_EN
         o_err   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  n_q     <= i_modulus;
                  rem_q   <= i_power;
                  i_ready <= 1'b0;
                  if (i_modulus == '0) begin
                     state   <= DONE;
                     o_valid <= 1'b1;
                     o_out   <= '0;
`ifdef RSA_TWO_POWER_MOD_ERR_EN
                     o_err   <= 1'b1;
`endif
                  end else if (i_power == '0) begin
                     state   <= DONE;
                     o_valid <= 1'b1;
                     o_out   <= n_is_one ? '0 : WIDTH'(1);
                  end else begin
                     state   <= CALC;
                     acc_q   <= n_is_one ? '0 : (WIDTH+1)'(1);
                  end
               end
            end
            CALC: begin
               acc_q <= acc_nxt;
               rem_q <= rem_nxt;
               if (rem_nxt == '0) begin
                  state   <= DONE;
                  o_valid <= 1'b1;
                  o_out   <= acc_nxt[WIDTH-1:0];
               end
            end
            DONE: begin
               if (o_ready) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
`ifdef RSA_TWO_POWER_MOD_ERR_EN
                  o_err   <= 1'b0;
`endif
               end
            end
            default: begin
               state   <= IDLE;
               i_ready <= 1'b1;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
